mlaccel_memory: RTL and testbench

//   128 KiB byte-addressed main data memory of the ML accelerator.

---
 rtl/mlaccel_memory_if.sv | 14 +
 rtl/mlaccel_memory.sv | 84 ++++++++
 tb/tb_mlaccel_memory.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mlaccel_memory_if.sv
// Purpose : access bus of the accelerator main data memory (byte write / 32-bit read).
// Latency : n/a (signal bundle only); rdata follows addr by one clock.
// Backpressure: none; the memory accepts one operation every cycle.
// Signals : addr  17-bit byte address, wen 1=write byte, wdata write byte,
//           rdata registered little-endian read word.
interface mlaccel_memory_if;
  logic [16:0] addr;
  logic        wen;
  logic [7:0]  wdata;
  logic [31:0] rdata;

  modport master (output addr, output wen, output wdata, input rdata);
  modport slave  (input addr, input wen, input wdata, output rdata);
endinterface

// File: rtl/mlaccel_memory.sv
// Purpose : 128 KiB byte-addressed data memory, four byte-wide banks interleaved on addr[1:0];
//           one byte write or one unaligned 32-bit read (addr..addr+3, wrapping) per cycle.
// Latency : 1 cycle, read-before-write. Backpressure: none, full rate, no handshake.
// Ports   : clock (posedge), resetn (sync, active-low; zeroes rdata, blocks writes,
//           keeps contents), bus (slave modport: addr, wen, wdata -> rdata).
module mlaccel_memory (
  input  logic              clock,
  input  logic              resetn,
  mlaccel_memory_if.slave   bus
);

  localparam int ROWS = 32768;

  logic [1:0]  a_lo;
  logic [14:0] a_row;
  logic [14:0] a_row_next;

  // Per-bank read row and captured bank output.
  logic [14:0] rd_row [4];
  logic [7:0]  bank_q [4];

  // Low address bits travel with the read so the registered bank outputs
  // can be put back into byte order.
  logic [1:0]  lo_q;
  // Forces rdata to zero for the cycle after a reset edge, since the bank
  // output registers themselves are never reset.
  logic        zero_q;

  logic [31:0] banks_cat;

  assign a_lo       = bus.addr[1:0];
  assign a_row      = bus.addr[16:2];
  assign a_row_next = a_row + 15'd1;   // wraps 0x7FFF -> 0 for the top-of-memory case

  // Bytes a..a+3 land in banks a_lo..3 on the current row; banks below a_lo
  // hold the bytes that spilled over into the next row.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_row[k] = (2'(k) >= a_lo) ? a_row : a_row_next;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_bank
    logic [7:0] mem [ROWS];

    // Write and read share the edge; the read samples the old contents,
    // giving read-before-write even for the byte being written.
    always_ff @(posedge clock) begin
      if (resetn && bus.wen && (a_lo == 2'(k))) begin
        mem[a_row] <= bus.wdata;
      end
      if (resetn) begin
        bank_q[k] <= mem[rd_row[k]];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      lo_q   <= 2'd0;
      zero_q <= 1'b1;
    end else begin
      lo_q   <= a_lo;
      zero_q <= 1'b0;
    end
  end

  assign banks_cat = {bank_q[3], bank_q[2], bank_q[1], bank_q[0]};

  // Rotate right by one byte per unit of the registered low address so that
  // byte a ends up in rdata[7:0].
  always_comb begin
    bus.rdata = 32'h0;
    if (!zero_q) begin
      case (lo_q)
        2'd0:    bus.rdata = banks_cat;
        2'd1:    bus.rdata = {banks_cat[7:0],  banks_cat[31:8]};
        2'd2:    bus.rdata = {banks_cat[15:0], banks_cat[31:16]};
        default: bus.rdata = {banks_cat[23:0], banks_cat[31:24]};
      endcase
    end
  end

endmodule

// File: tb/tb_mlaccel_memory.sv
module tb_mlaccel_memory;

  localparam int N = 131072;

  logic clock;
  logic resetn;
  mlaccel_memory_if bus ();

  mlaccel_memory dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: flat byte array plus a written-flag per byte.
  logic [7:0] model [N];
  bit         known [N];

  int n_assert = 0;
  int n_fail   = 0;

  // One clock of stimulus; checks rdata against the model on every byte the
  // model knows (all bytes forced to zero while in reset).
  task automatic cyc(input logic [16:0] a, input logic w, input logic [7:0] d,
                     input logic rn, input string tag);
    logic [31:0] exp_v, mask;
    logic [16:0] ai;
    bus.addr  = a;
    bus.wen   = w;
    bus.wdata = d;
    resetn    = rn;
    exp_v = 32'h0;
    mask  = 32'h0;
    if (!rn) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      for (int i = 0; i < 4; i++) begin
        ai = a + 17'(i);
        if (known[ai]) begin
          exp_v[8*i +: 8] = model[ai];
          mask[8*i +: 8]  = 8'hFF;
        end
      end
    end
    @(posedge clock);
    if (rn && w) begin
      model[a] = d;
      known[a] = 1'b1;
    end
    #1;
    if (mask != 32'h0) begin
      n_assert++;
      assert ((bus.rdata & mask) === exp_v) else begin
        n_fail++;
        $error("FAIL %s addr=%05h observed=%08h expected=%08h bytemask=%08h",
               tag, a, bus.rdata, exp_v, mask);
      end
    end
  endtask

  // Fixed expected values taken straight from the intended behaviour.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) known[i] = 1'b0;
    bus.addr = '0; bus.wen = 1'b0; bus.wdata = '0; resetn = 1'b0;

    // Power-up reset
    cyc(17'h0, 1'b0, 8'h0, 1'b0, "reset0");
    cyc(17'h0, 1'b0, 8'h0, 1'b0, "reset1");
    chk("reset_rdata", bus.rdata, 32'h0);

    // 1. Fill 0..999 with low address byte
    for (int i = 0; i < 1000; i++) cyc(17'(i), 1'b1, 8'(i), 1'b1, "fill");
    cyc(17'd0, 1'b0, 8'h0, 1'b1, "rd0");
    chk("read_0", bus.rdata, 32'h03020100);
    cyc(17'd4, 1'b0, 8'h0, 1'b1, "rd4");
    chk("read_4", bus.rdata, 32'h07060504);

    // 2. Unaligned
    cyc(17'd5, 1'b0, 8'h0, 1'b1, "rd5");
    chk("read_5", bus.rdata, 32'h08070605);
    cyc(17'd255, 1'b0, 8'h0, 1'b1, "rd255");
    chk("read_255", bus.rdata, 32'h020100FF);
    cyc(17'd998, 1'b0, 8'h0, 1'b1, "rd998");
    chk("read_998_lo16", {16'h0, bus.rdata[15:0]}, 32'h0000E7E6);

    // 3. Streaming, no bubbles
    for (int n = 0; n < 40; n++) begin
      cyc(17'(n), 1'b0, 8'h0, 1'b1, "stream");
      chk("stream_const", bus.rdata, {8'(n + 3), 8'(n + 2), 8'(n + 1), 8'(n)});
    end

    // 4. Wrap-around
    cyc(17'h1FFFE, 1'b1, 8'hAA, 1'b1, "wr_1fffe");
    cyc(17'h1FFFF, 1'b1, 8'hBB, 1'b1, "wr_1ffff");
    cyc(17'h00000, 1'b1, 8'hCC, 1'b1, "wr_0");
    cyc(17'h00001, 1'b1, 8'hDD, 1'b1, "wr_1");
    cyc(17'h1FFFE, 1'b0, 8'h0, 1'b1, "rd_1fffe");
    chk("wrap_1fffe", bus.rdata, 32'hDDCCBBAA);
    cyc(17'h1FFFF, 1'b0, 8'h0, 1'b1, "rd_1ffff");
    chk("wrap_1ffff", bus.rdata, 32'h02DDCCBB);
    // restore bytes 0,1 for the reset check below
    cyc(17'h00000, 1'b1, 8'h00, 1'b1, "restore0");
    cyc(17'h00001, 1'b1, 8'h01, 1'b1, "restore1");

    // 5. Read-during-write
    cyc(17'd10, 1'b1, 8'h55, 1'b1, "rdw_write");
    chk("rdw_old_byte", {24'h0, bus.rdata[7:0]}, 32'h0000000A);
    cyc(17'd10, 1'b0, 8'h0, 1'b1, "rdw_next");
    chk("rdw_new_byte", {24'h0, bus.rdata[7:0]}, 32'h00000055);

    // 6. Reset with a pending write that must be suppressed
    cyc(17'd0, 1'b1, 8'hFF, 1'b0, "rst_a");
    chk("rst_a_zero", bus.rdata, 32'h0);
    cyc(17'd0, 1'b1, 8'hFF, 1'b0, "rst_b");
    chk("rst_b_zero", bus.rdata, 32'h0);
    cyc(17'd0, 1'b0, 8'h0, 1'b1, "post_rst");
    chk("post_reset_read0", bus.rdata, 32'h03020100);

    // Random mix of reads/writes across low region and top-of-memory wrap zone
    for (int i = 0; i < 600; i++) begin
      logic [16:0] ra;
      logic        rw;
      if ($urandom_range(0, 3) == 0) ra = 17'h1FFF0 + 17'($urandom_range(0, 15));
      else                           ra = 17'($urandom_range(0, 1100));
      rw = ($urandom_range(0, 2) == 0);
      cyc(ra, rw, 8'($urandom), 1'b1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
